// File: rtl/input_event_unit.sv
// input_event_unit: two-flop sync and tick-based debounce of N_CH inputs; each accepted edge is queued as a {ch, level, ts} event.
// Latency: raw->synced 2 clk, flip at edge T -> FIFO write at T+1 -> ev_valid after T+2. INPUT_EVENT_RELEASE_EN also queues falling edges.
// Backpressure: a full FIFO holds pending bits (no loss); a re-flip of a still-pending channel keeps the newest level and sets overflow.

// event_fifo: generic first-word-fall-through FIFO with the head held in an output register.
// Latency: a write into an empty FIFO at edge E shows out_vld after E+1; count includes the head register.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [W-1:0]           in_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W-1:0]           out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic          push;
  logic          pop;
  logic          load;

  assign pop    = out_vld && out_rdy;
  assign count  = mem_cnt + CW'(out_vld);
  assign in_rdy = (count < CW'(DEPTH)) || pop;
  assign push   = in_vld && in_rdy;
  // Refill the head whenever it is empty or being consumed this cycle.
  assign load   = (mem_cnt != '0) && (!out_vld || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_dat <= mem[rd_ptr];
      end
      out_vld <= load || (out_vld && !pop);
      case ({push, load})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module input_event_unit #(
  parameter int N_CH         = 18,
  parameter int DEBOUNCE_DIV = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int TS_W         = 14,
  parameter int FIFO_DEPTH   = 16,
  parameter int CH_W         = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             raw_in,
  input  logic                        sample_tick,
  output logic [N_CH-1:0]             state_out,
  output logic [TS_W-1:0]             ts_out,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [CH_W-1:0]             ev_channel,
  output logic                        ev_level,
  output logic [TS_W-1:0]             ev_ts,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow,
  input  logic                        overflow_clr
);
  localparam int DIV_W = $clog2(DEBOUNCE_DIV);
  localparam int DB_W  = $clog2(STABLE_TICKS) + 1;
`ifdef INPUT_EVENT_RELEASE_EN
  localparam int EV_W  = CH_W + 1 + TS_W;
`else
  localparam int EV_W  = CH_W + TS_W;
`endif

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  synced;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [DB_W-1:0]  db_cnt [N_CH];
  logic [N_CH-1:0]  flip;
  logic [N_CH-1:0]  flip_evt;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  grant_oh;
  logic [CH_W-1:0]  grant_ch;
  logic             grant_any;
  logic             push_rdy;
  logic             ovf_set;
  logic [EV_W-1:0]  push_dat;
  logic [EV_W-1:0]  head_dat;

  assign tick = (div_cnt == DIV_W'(DEBOUNCE_DIV - 1));

  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++)
      flip[i] = tick && (synced[i] != state_out[i]) && (db_cnt[i] == DB_W'(STABLE_TICKS - 1));
  end

`ifdef INPUT_EVENT_RELEASE_EN
  logic [N_CH-1:0] pend_level;

  assign flip_evt = flip;
  assign push_dat = {grant_ch, pend_level[grant_ch], ts_out};
  assign {ev_channel, ev_level, ev_ts} = head_dat;

  // A flip of a still-pending channel simply overwrites the queued level.
  always_ff @(posedge clk) begin
    if (rst) pend_level <= '0;
    else     pend_level <= (pend_level & ~flip_evt) | (synced & flip_evt);
  end
`else
  assign flip_evt = flip & synced;
  assign push_dat = {grant_ch, ts_out};
  assign {ev_channel, ev_ts} = head_dat;
  assign ev_level = 1'b1;
`endif

  // Lowest index wins: scan downwards so the last hit is the smallest channel.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_any && push_rdy) grant_oh[grant_ch] = 1'b1;
  end

  // A channel granted this cycle has its old event written, so re-flipping it is not a loss.
  assign ovf_set = |(flip_evt & pending & ~grant_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      synced    <= '0;
      div_cnt   <= '0;
      state_out <= '0;
      pending   <= '0;
      ts_out    <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw_in;
      synced  <= sync1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        for (int i = 0; i < N_CH; i++)
          db_cnt[i] <= ((synced[i] == state_out[i]) || flip[i]) ? '0 : db_cnt[i] + 1'b1;
      end
      state_out <= state_out ^ flip;
      pending   <= (pending & ~grant_oh) | flip_evt;
      if (sample_tick) ts_out <= ts_out + 1'b1;
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (grant_any),
    .in_rdy  (push_rdy),
    .in_dat  (push_dat),
    .out_vld (ev_valid),
    .out_rdy (ev_ready),
    .out_dat (head_dat),
    .count   (ev_count)
  );
endmodule

// File: doc/input_event_unit.md
Name: input_event_unit

Overview:
- Parametrised successor to the per-pin sync/debounce chains that feed the HPS `inputs` word.
- Synchronises and debounces N_CH raw inputs (KEY, SW, keyboard GPIO) and exposes their stable levels.
- Also turns every debounced edge into a timestamped event and queues it in an event FIFO for the HPS.
- The timestamp is a free-running counter advanced by the audio sample strobe (`wr_ready`), so HPS sees event times in sample units.

Parameters:
- N_CH, 18, number of input channels.
- DEBOUNCE_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be ≥2.
- STABLE_TICKS, 8, consecutive ticks a changed level must persist before it is accepted; must be ≥1.
- TS_W, 14, timestamp width.
- FIFO_DEPTH, 16, event FIFO entries; power of two.
- CH_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- raw_in  in  N_CH  asynchronous raw inputs.
- sample_tick  in  1  one-cycle audio sample strobe.
- state_out  out  N_CH  debounced levels.
- ts_out  out  TS_W  current timestamp counter.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer pop.
- ev_channel  out  CH_W  head channel index.
- ev_level  out  1  head new level.
- ev_ts  out  TS_W  head timestamp.
- ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky lost/coalesced-event flag.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: all of the following go to 0 on the clk edge where rst=1:
  - sync flops, prescaler, per-channel counters, state_out, pending bits;
  - ts_out, FIFO pointers, ev_valid, ev_count, overflow.
  - A reset mid-operation discards queued events.
  - An input held high through reset produces a rising event after the normal debounce window.
- Sync: two flops per channel; `synced` lags raw_in by 2 cycles.
- Prescaler: counts 0..DEBOUNCE_DIV-1 and wraps; `tick` is asserted for the one cycle where the count equals DEBOUNCE_DIV-1.
- Per-channel debounce: a counter of width $clog2(STABLE_TICKS)+1, updated only on tick:
  - synced==state: counter cleared.
  - synced!=state and counter==STABLE_TICKS-1: state flips to synced, counter cleared, pending[ch] set, pend_level[ch] set to the new level.
  - otherwise: counter increments.
  - A glitch shorter than STABLE_TICKS ticks never changes state_out.
- Pending merge: if pending[ch] is already set when ch flips again, pend_level takes the newest level and overflow is set. Only the latest level is kept.
- Arbiter: each cycle with FIFO not full, the lowest-index pending channel is written to the FIFO.
  - Written entry: {ch, pend_level[ch], ts_out at the write cycle}.
  - pending[ch] clears in the same cycle; one write per cycle.
  - With the FIFO full, pending bits hold. This is backpressure, not loss.
- Latency: a debounced flip registers at edge T; its FIFO write occurs at edge T+1 (if uncontended and not full); ev_valid is high after T+2 (first-word-fall-through register).
- FIFO:
  - ev_* show the head whenever ev_valid=1. A pop is ev_valid&&ev_ready.
  - A push and pop in the same cycle leaves ev_count unchanged and is legal when full.
  - ev_ready while empty is ignored.
- Timestamp: ts_out increments on sample_tick and wraps from 2^TS_W-1 to 0. A timestamp taken in the same cycle as the increment uses the pre-increment value.
- overflow: cleared by overflow_clr. If a set and a clear occur in the same cycle, the set wins.

Optional Feature:
- INPUT_EVENT_RELEASE_EN defined: both rising and falling debounced edges generate events.
- Undefined:
  - Only 0→1 flips set pending and ev_level is constant 1.
  - Falling flips still update state_out but generate no event and never set overflow.
  - A pending rising event is never coalesced by a fall.

Test Plan (DEBOUNCE_DIV=4, STABLE_TICKS=3, N_CH=4, FIFO_DEPTH=4, RELEASE_EN defined):
- raw_in[2] 0→1 held → state_out[2] rises after the 3rd tick with a difference (~14 cycles); one event {ch=2, level=1, ts=ts_out at write}; ev_count=1.
- raw_in[1] pulsed high for 5 cycles (<3 ticks) → state_out unchanged, no event, overflow=0.
- raw_in[3:0]=4'b1111 at once, ev_ready=0 → FIFO order ch0, ch1, ch2, ch3; ev_count=4; the ch0 write precedes the ch3 write by 3 cycles.
- FIFO full with 4 entries, ch0 rises then falls again before a pop → overflow=1, pending ch0 level=0; after 1 pop, entry {ch0, level 0} is written; overflow_clr→0.
- sample_tick pulsed 2^14 times → ts_out wraps to 0; an event written in the wrap cycle carries ts=16383.
- Assert rst with 3 queued events and a counter mid-count → next cycle ev_valid=0, ev_count=0, state_out=0, ts_out=0; raw_in still high yields a fresh rising event after 3 ticks.
